// File: rtl/ysyx_23060072_fetch_ctrl.sv
// Purpose : single-cycle instruction fetch with an IF/ID pipeline register,
//           redirect handling and an optional static JAL predictor.
// Latency : fetch address out and ROM word back in the same cycle, captured at
//           the next edge; redirect at edge N gives a valid target after N+1.
// Backpr. : the IF/ID register and pc_q hold while id_valid_o && !id_ready_i.
//           redirect_i overrides a stall.
//
// Optional feature: define YSYX_23060072_FETCH_JAL_PRED_EN to predict every
// JAL as taken. Without it, fetch is strictly sequential and
// id_pred_taken_o is 0.
//
// Ports:
//   clk, rst              clock and asynchronous active-high reset
//   ifu_addr_o            ROM word index, (pc_q - RESET_PC) >> 2
//   ifu_rdata_i           ROM word for ifu_addr_o, same cycle
//   redirect_i            EX-stage redirect request
//   redirect_pc_i         redirect target; the low two bits are ignored
//   id_ready_i            ID can take the IF/ID contents this cycle
//   id_valid_o            IF/ID holds a valid instruction
//   id_pc_o               byte PC of the instruction in IF/ID
//   id_inst_o             instruction word in IF/ID
//   id_pred_taken_o       fetch after this instruction followed a predicted JAL
//   fetch_cnt_o           number of instructions ID has consumed
module ysyx_23060072_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] ifu_addr_o,
  input  logic [31:0] ifu_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        id_ready_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_pred_taken_o,
  output logic [31:0] fetch_cnt_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] pc_q,    pc_d;
  logic        valid_q, valid_d;
  logic [31:0] idpc_q,  idpc_d;
  logic [31:0] inst_q,  inst_d;
  logic        pred_q,  pred_d;
  logic [31:0] cnt_q,   cnt_d;

  logic        accept;
  logic [31:0] next_pc;
  logic        pred_next;

  // The ROM index depends on pc_q alone, which keeps id_ready_i and
  // redirect_i off the address path.
  assign ifu_addr_o = (pc_q - RESET_PC) >> 2;

  assign accept = !valid_q || id_ready_i;

`ifdef YSYX_23060072_FETCH_JAL_PRED_EN
  logic        is_jal;
  logic [20:0] jimm;

  assign is_jal    = (ifu_rdata_i[6:0] == 7'b1101111);
  assign jimm      = {ifu_rdata_i[31], ifu_rdata_i[19:12], ifu_rdata_i[20],
                      ifu_rdata_i[30:21], 1'b0};
  assign next_pc   = is_jal ? (pc_q + {{11{jimm[20]}}, jimm}) : (pc_q + 32'd4);
  assign pred_next = is_jal;
`else
  assign next_pc   = pc_q + 32'd4;
  assign pred_next = 1'b0;
`endif

  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    idpc_d  = idpc_q;
    inst_d  = inst_q;
    pred_d  = pred_q;
    cnt_d   = cnt_q;

    // ID consumes the instruction whenever it is valid and ready, even in a
    // redirect cycle, so the count does not look at redirect_i.
    if (valid_q && id_ready_i) begin
      cnt_d = cnt_q + 32'd1;
    end

    if (redirect_i) begin
      pc_d    = {redirect_pc_i[31:2], 2'b00};
      valid_d = 1'b0;
      inst_d  = NOP;
      pred_d  = 1'b0;
    end else if (accept) begin
      pc_d    = next_pc;
      valid_d = 1'b1;
      idpc_d  = pc_q;
      inst_d  = ifu_rdata_i;
      pred_d  = pred_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      idpc_q  <= 32'h0;
      inst_q  <= NOP;
      pred_q  <= 1'b0;
      cnt_q   <= 32'h0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      idpc_q  <= idpc_d;
      inst_q  <= inst_d;
      pred_q  <= pred_d;
      cnt_q   <= cnt_d;
    end
  end

  assign id_valid_o      = valid_q;
  assign id_pc_o         = idpc_q;
  assign id_inst_o       = inst_q;
  assign id_pred_taken_o = pred_q;
  assign fetch_cnt_o     = cnt_q;

endmodule

// File: tb/tb_ysyx_23060072_fetch_ctrl.sv
// Purpose : bench for ysyx_23060072_fetch_ctrl, with a small ROM and a
//           per-edge reference model of the fetch rules.
// Latency : outputs are checked 1 time unit after each rising edge.
// Backpr. : id_ready_i is driven by directed steps and then randomly.
module tb_ysyx_23060072_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef YSYX_23060072_FETCH_JAL_PRED_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ifu_addr_o;
  logic [31:0] ifu_rdata_i;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        id_ready_i = 1'b0;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_pred_taken_o;
  logic [31:0] fetch_cnt_o;

  logic [31:0] rom [64];

  int tests = 0;
  int fails = 0;

  // Reference state.
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_idpc;
  logic [31:0] m_inst;
  logic        m_pred;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  // Words outside the table are non-JAL ALU ops that encode their own index.
  assign ifu_rdata_i = (ifu_addr_o < 32'd64) ? rom[ifu_addr_o[5:0]]
                                             : {ifu_addr_o[24:0], 7'b0010011};

  ysyx_23060072_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .ifu_addr_o      (ifu_addr_o),
    .ifu_rdata_i     (ifu_rdata_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .id_ready_i      (id_ready_i),
    .id_valid_o      (id_valid_o),
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o),
    .id_pred_taken_o (id_pred_taken_o),
    .fetch_cnt_o     (fetch_cnt_o)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] idx);
    if (idx < 32'd64) return rom[idx[5:0]];
    return {idx[24:0], 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_jal(input int offset);
    logic [20:0] imm;
    imm = 21'(offset);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, {31'b0, id_valid_o},      {31'b0, m_valid});
    chk({tag, ".pc"},    id_pc_o,                  m_idpc);
    chk({tag, ".inst"},  id_inst_o,                m_inst);
    chk({tag, ".pred"},  {31'b0, id_pred_taken_o}, {31'b0, m_pred});
    chk({tag, ".cnt"},   fetch_cnt_o,              m_cnt);
    chk({tag, ".addr"},  ifu_addr_o,               (m_pc - RESET_PC) >> 2);
  endtask

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_valid = 1'b0;
    m_idpc  = 32'h0;
    m_inst  = NOP;
    m_pred  = 1'b0;
    m_cnt   = 32'h0;
  endtask

  // Applies one rising edge given the inputs that were stable before it.
  task automatic model_edge(input logic r, input logic rd, input logic [31:0] rpc);
    logic [31:0] word;
    logic [20:0] j;
    bit          take;
    word = rom_word((m_pc - RESET_PC) >> 2);
    if (m_valid && rd) m_cnt = m_cnt + 32'd1;
    if (r) begin
      m_pc    = rpc & 32'hFFFF_FFFC;
      m_valid = 1'b0;
      m_inst  = NOP;
      m_pred  = 1'b0;
    end else if (!m_valid || rd) begin
      take    = PRED_EN && (word[6:0] == 7'b1101111);
      j       = {word[31], word[19:12], word[20], word[30:21], 1'b0};
      m_idpc  = m_pc;
      m_inst  = word;
      m_valid = 1'b1;
      m_pred  = take;
      m_pc    = take ? m_pc + {{11{j[20]}}, j} : m_pc + 32'd4;
    end
  endtask

  task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input string tag);
    redirect_i    = r;
    id_ready_i    = rd;
    redirect_pc_i = rpc;
    @(posedge clk);
    model_edge(r, rd, rpc);
    #1;
    check_all(tag);
  endtask

  // Reset arrives mid-cycle; outputs must change without waiting for an edge.
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_all({tag, ".async"});
    @(negedge clk);
    rst        = 1'b0;
    redirect_i = 1'b0;
    id_ready_i = 1'b0;
    #1;
    check_all({tag, ".rel"});
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = {12'(i), 5'd0, 3'b000, 5'd1, 7'b0010011};

    // Sequential fetch from reset.
    do_reset("rst0");
    chk("rst0.valid0", {31'b0, id_valid_o}, 32'd0);
    chk("rst0.inst",   id_inst_o,           NOP);
    step(1'b0, 1'b1, 32'h0, "seq1");
    chk("seq1.pc", id_pc_o, 32'h8000_0000);
    step(1'b0, 1'b1, 32'h0, "seq2");
    chk("seq2.pc",  id_pc_o,     32'h8000_0004);
    chk("seq2.cnt", fetch_cnt_o, 32'd1);
    step(1'b0, 1'b1, 32'h0, "seq3");
    chk("seq3.pc",  id_pc_o,     32'h8000_0008);
    chk("seq3.cnt", fetch_cnt_o, 32'd2);
    step(1'b0, 1'b1, 32'h0, "seq4");
    chk("seq4.cnt", fetch_cnt_o, 32'd3);

    // Stall for three cycles.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0, "stall");
      chk("stall.pc",   id_pc_o,     32'h8000_000C);
      chk("stall.addr", ifu_addr_o,  32'd4);
      chk("stall.cnt",  fetch_cnt_o, 32'd3);
    end

    // Misaligned redirect during a stall.
    step(1'b1, 1'b0, 32'h8000_0042, "redir");
    chk("redir.valid", {31'b0, id_valid_o}, 32'd0);
    chk("redir.addr",  ifu_addr_o,          32'h10);
    step(1'b0, 1'b0, 32'h0, "redir2");
    chk("redir2.pc", id_pc_o, 32'h8000_0040);

    // PC wraps past the top of the address space.
    step(1'b1, 1'b1, 32'hFFFF_FFFC, "wrap0");
    step(1'b0, 1'b1, 32'h0, "wrap1");
    chk("wrap1.pc", id_pc_o, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 32'h0, "wrap2");
    chk("wrap2.pc", id_pc_o, 32'h0000_0000);

    // Reset in the middle of a stall.
    step(1'b0, 1'b0, 32'h0, "prestall");
    do_reset("rst1");
    chk("rst1.cnt", fetch_cnt_o, 32'd0);
    step(1'b0, 1'b1, 32'h0, "rst1.first");
    chk("rst1.first.pc", id_pc_o, RESET_PC);

    // JAL +16 at the reset PC.
    rom[0] = 32'h0100_006F;
    do_reset("jal");
    step(1'b0, 1'b1, 32'h0, "jal1");
    chk("jal1.pc",   id_pc_o, 32'h8000_0000);
    chk("jal1.pred", {31'b0, id_pred_taken_o}, PRED_EN ? 32'd1 : 32'd0);
    step(1'b0, 1'b1, 32'h0, "jal2");
    chk("jal2.pc", id_pc_o, PRED_EN ? 32'h8000_0010 : 32'h8000_0004);

    // Random ROM contents, backpressure and redirects.
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 3) == 0)
        rom[i] = enc_jal(($urandom_range(0, 16) - 8) * 4);
      else
        rom[i] = {$urandom_range(0, 32'h01FF_FFFF) , 7'b0010011};
    end
    do_reset("rnd");
    for (int n = 0; n < 3000; n++) begin
      logic        r;
      logic        rd;
      logic [31:0] rpc;
      r  = ($urandom_range(0, 9) == 0);
      rd = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0:       rpc = $urandom;
        1:       rpc = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
        default: rpc = RESET_PC + 32'($urandom_range(0, 255));
      endcase
      step(r, rd, rpc, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
